// File: rtl/cave_reg_file_pkg.sv
// Shared constants and helpers for the cave_reg_file control register block.
package cave_reg_file_pkg;

    localparam logic [7:0] RESET_BYTE = 8'h00;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // One byte lane of a masked write: take the new byte only when its enable is set.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/cave_reg_file_shadow.sv
// Shadow bank for cave_reg_file: loads the whole live bank when commit is high.
// Only instantiated when CAVE_REG_FILE_SHADOW_EN is defined.
module cave_reg_file_shadow
    import cave_reg_file_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             commit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= {(WIDTH / 8){RESET_BYTE}};
        end else if (commit) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cave_reg_file.sv
// Parametrised control register file with byte masks, registered read/ack and change strobes.
// Optional feature macro: CAVE_REG_FILE_SHADOW_EN (adds io_commit and a shadowed io_regs bank).
module cave_reg_file
    import cave_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        io_mem_rd,
    input  logic                        io_mem_wr,
    input  logic [ADDR_WIDTH-1:0]       io_mem_addr,
    input  logic [DATA_WIDTH/8-1:0]     io_mem_mask,
    input  logic [DATA_WIDTH-1:0]       io_mem_din,
    output logic [DATA_WIDTH-1:0]       io_mem_dout,
    output logic                        io_mem_ack,
    output logic [DEPTH*DATA_WIDTH-1:0] io_regs,
`ifdef CAVE_REG_FILE_SHADOW_EN
    input  logic                        io_commit,
`endif
    output logic [DEPTH-1:0]            io_changed
);

    localparam int BYTES = bytes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]            hit;
    logic [DATA_WIDTH-1:0]       rd_word;
    logic [DEPTH*DATA_WIDTH-1:0] live_flat;

    // One-hot address decode; out-of-range addresses hit nothing, so they
    // neither write nor pulse io_changed, and read back as zero.
    always_comb begin
        hit     = '0;
        rd_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = (io_mem_addr == ADDR_WIDTH'(k));
            if (hit[k]) begin
                rd_word = regs[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= {BYTES{RESET_BYTE}};
            end
            io_changed  <= '0;
            io_mem_dout <= {BYTES{RESET_BYTE}};
            io_mem_ack  <= 1'b0;
        end else begin
            io_mem_ack <= io_mem_rd | io_mem_wr;
            if (io_mem_rd) begin
                io_mem_dout <= rd_word;
            end
            for (int k = 0; k < DEPTH; k++) begin
                io_changed[k] <= io_mem_wr && hit[k] && (|io_mem_mask);
                for (int b = 0; b < BYTES; b++) begin
                    if (io_mem_wr && hit[k]) begin
                        regs[k][b*8 +: 8] <= merge_byte(regs[k][b*8 +: 8],
                                                        io_mem_din[b*8 +: 8],
                                                        io_mem_mask[b]);
                    end
                end
            end
        end
    end

    always_comb begin
        live_flat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            live_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end

`ifdef CAVE_REG_FILE_SHADOW_EN
    cave_reg_file_shadow #(
        .WIDTH (DEPTH * DATA_WIDTH)
    ) u_shadow (
        .clock   (clock),
        .reset_n (reset_n),
        .commit  (io_commit),
        .d       (live_flat),
        .q       (io_regs)
    );
`else
    assign io_regs = live_flat;
`endif

endmodule

// File: doc/cave_reg_file.md
Name: cave_reg_file

Overview:
- Parametrised memory-mapped control register file: generalises the fixed 4 x 16-bit, whole-word-write register block.
- Adds configurable depth and width, per-byte write masks, a registered read port with acknowledge, and per-register change strobes.
- Sits between the CPU bus decoder and video/sound sub-blocks; every register is exported in parallel to consumers.

Parameters:
- DATA_WIDTH, 16, register width in bits; multiple of 8.
- DEPTH, 4, number of registers; 1..64, need not be a power of 2.
- ADDR_WIDTH, 2, address bits; ADDR_WIDTH >= ceil(log2(DEPTH)), minimum 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- io_mem_rd  in  1  read request, single-cycle strobe.
- io_mem_wr  in  1  write request, single-cycle strobe.
- io_mem_addr  in  ADDR_WIDTH  register index.
- io_mem_mask  in  DATA_WIDTH/8  byte write enables; bit i selects byte i.
- io_mem_din  in  DATA_WIDTH  write data.
- io_mem_dout  out  DATA_WIDTH  read data; valid while io_mem_ack is high.
- io_mem_ack  out  1  acknowledge, one cycle after any accepted rd or wr.
- io_regs  out  DEPTH*DATA_WIDTH  all registers flattened; register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- io_changed  out  DEPTH  one-cycle pulse per register, high the cycle after a write that modified it.

Behaviour:
- Reset (reset_n low at a clock edge): all registers 0, io_mem_dout 0, io_mem_ack 0, io_changed 0. Reset overrides a same-cycle rd/wr; that request is dropped and not acked.
- Write: when io_mem_wr is high and addr < DEPTH, each byte i of reg[addr] takes din byte i if mask[i] is set, else it holds.
  - The new value is visible on io_regs the next cycle.
  - A write with mask all zero is still acked and does not pulse io_changed.
- io_changed[k]: registered; high for exactly one cycle after a write to k with any mask bit set, even if the value is unchanged.
- Read: when io_mem_rd is high, io_mem_dout is registered to reg[addr] (pre-write value) and io_mem_ack is high the next cycle. Latency is 1, with no wait states.
- rd and wr in the same cycle: the write is performed, dout returns the old value, and a single ack is issued.
- io_mem_ack = registered (rd | wr). Back-to-back requests every cycle are legal, giving continuous ack.
- io_mem_dout holds its last value when there is no read; it is not cleared.
- addr >= DEPTH: writes are ignored (no change, no io_changed pulse) but acked; reads return 0 and are acked.
- No internal FSM beyond the request/ack pipeline register; no stall or backpressure.

Optional Feature:
- Macro: CAVE_REG_FILE_SHADOW_EN.
- Defined:
  - Adds input io_commit (1 bit).
  - io_regs is driven from a shadow bank, not the live registers.
  - The shadow copies the entire live bank on the cycle after io_commit is high; used for vblank-synchronised updates.
  - A write and io_commit in the same cycle: the shadow captures the pre-write value, and the write reaches the shadow on the next commit.
  - Reset clears the shadow to 0.
  - io_mem_dout always reads live registers; io_changed is unaffected.
- Undefined: no io_commit port; io_regs is driven directly from the live registers.

Decomposition:
- Package cave_reg_file_pkg holds:
  - function bytes_of(DATA_WIDTH);
  - function for the masked-merge of old and new words;
  - localparam for reset value 0.
- Sub-module cave_reg_file_shadow (DEPTH*DATA_WIDTH-bit bank with commit load), instantiated only under CAVE_REG_FILE_SHADOW_EN.
- All other logic stays in the top level.

Test Plan:
- Reset: hold reset_n low 2 cycles after random writes -> io_regs all 0, io_mem_ack 0, io_changed 0.
- Masked write: reg1=0x1234, then wr addr1 mask=2'b10 din=0xABCD -> next cycle io_regs reg1=0xAB34, io_changed=4'b0010 for 1 cycle, ack for 1 cycle.
- Read latency plus simultaneous rd/wr: reg2=0x5555, then rd+wr addr2 din=0xAAAA mask=11 -> next cycle dout=0x5555 and ack=1; a subsequent rd returns 0xAAAA.
- Out of range: DEPTH=3, ADDR_WIDTH=2, wr addr3 din=0xFFFF -> no register changes, io_changed=0, ack=1; rd addr3 -> dout=0.
- Back-to-back: 8 consecutive alternating wr/rd to addr0..3 -> ack high 8 consecutive cycles, each dout matches the prior write.
- Shadow (macro defined): wr reg0=0x00FF -> io_regs reg0 stays 0; pulse io_commit -> next cycle io_regs reg0=0x00FF.
